// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_BITS = 8;

    // Rounded clocks-per-bit for a given system clock and line rate.
    function automatic int calc_clk_div(input int unsigned clk_hz, input int unsigned baud_hz);
        return int'((clk_hz + (baud_hz / 32'd2)) / baud_hz);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; occupancy counter drives full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             wr_en_s, rd_en_s;

    assign full  = (fill_q == FILL_MAX);
    assign empty = (fill_q == {(AW + 1){1'b0}});
    assign fill  = fill_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    always_comb begin
        rd_en_s  = pop && !empty;
        wr_en_s  = push && (!full || rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            fill_q   <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; contents need no reset since fill gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchronizer, sticky error flags and a byte FIFO
// presented on a valid/ready interface.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = calc_clk_div(32'd100_000_000, 32'd5_000_000),
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);
    localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    uart_state_e            state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_BITS-1:0]   shreg_q, shreg_d;
    logic                   idle_seen_q, idle_seen_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic                   push_s, frame_set_s, overflow_set_s;
    logic                   pop_s, fifo_full_s, fifo_empty_s;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign m_valid   = !fifo_empty_s;
    assign pop_s     = m_valid && m_ready;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    sync_fifo #(
        .WIDTH (UART_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (shreg_q),
        .pop   (pop_s),
        .rdata (m_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .fill  (fill)
    );

    // Receiver FSM: half-bit wait to the start centre, then one sample per bit period.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        idle_seen_d = idle_seen_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_s) begin
                    idle_seen_d = 1'b1;
                end else if (idle_seen_q) begin
                    baud_d  = HALF_LOAD;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_q != 16'd0) begin
                    baud_d = baud_q - 16'd1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    baud_d  = FULL_LOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_q != 16'd0) begin
                    baud_d = baud_q - 16'd1;
                end else begin
                    shreg_d = {rx_s, shreg_q[UART_BITS-1:1]};
                    baud_d  = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q != 16'd0) begin
                    baud_d = baud_q - 16'd1;
                end else begin
                    state_d = IDLE;
                    if (rx_s) begin
                        push_s = 1'b1;
                    end else begin
                        // Line may be in a break; wait for it to go high before re-arming.
                        frame_set_s = 1'b1;
                        idle_seen_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a new error in the clearing cycle takes priority.
    always_comb begin
        overflow_set_s = push_s && fifo_full_s && !pop_s;
        if (frame_set_s) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        if (overflow_set_s) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, synchronizer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= {SYNC_STAGES{1'b1}};
            state_q     <= IDLE;
            baud_q      <= 16'd0;
            bit_q       <= 3'd0;
            shreg_q     <= {UART_BITS{1'b0}};
            idle_seen_q <= 1'b1;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            idle_seen_q <= idle_seen_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable 8N1 UART receiver that consumes the SoC serial output (ser_tx of rvsoc_wrapper) and converts it into a byte stream.
- Decoded bytes are buffered in a FIFO and presented on a valid/ready interface.
- Replaces behavioural serial decoding, so the byte stream can be checked in-design (self-checking benches, on-chip loopback to dataproc).
- Flags framing errors and FIFO overflow.

Parameters:
- CLK_DIV, 20, clocks per bit; 20 gives 5 Mbps at 100 MHz. Legal range 4..65535.
- FIFO_DEPTH, 16, byte entries; power of two, at least 2.
- SYNC_STAGES, 2, input synchronizer flops; at least 2.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- m_data  out  8  byte at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overflow  out  1  sticky: a byte arrived while the FIFO was full.
- err_clr  in  1  single-cycle pulse that clears both sticky flags.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=1 at posedge clk):
  - FSM goes to IDLE; bit and baud counters go to 0.
  - FIFO pointers go to 0.
  - m_valid, frame_err and overflow go to 0; fill goes to 0. m_data is don't-care while m_valid=0.
  - Synchronizer flops load 1 (idle).
  - Reset mid-frame abandons the partial byte; nothing is written.
- rx passes through SYNC_STAGES flops; rx_s is the synchronized value. All decisions use rx_s.
- FSM states:
  - IDLE: on rx_s==0, load baud_cnt=CLK_DIV/2-1 and go to START.
  - START: when baud_cnt reaches 0, sample rx_s.
    - If 1 (glitch), return to IDLE.
    - Else load baud_cnt=CLK_DIV-1, bit_idx=0, go to DATA.
  - DATA: on each baud_cnt==0, shift in rx_s LSB-first (shreg <= {rx_s, shreg[7:1]}) and reload CLK_DIV-1. After bit_idx==7 is sampled, go to STOP.
  - STOP: on baud_cnt==0, sample rx_s.
    - If 1: push shreg into the FIFO.
    - If 0: set frame_err and discard the byte.
    - Either way go to IDLE; a new start edge is accepted in the next cycle.
- Samples are taken at mid-bit, with ±1 clk quantisation plus SYNC_STAGES of latency.
- Push timing: the byte is written at the STOP sample edge. m_valid rises the following cycle if the FIFO was empty.
- Latency from the rx falling edge of the start bit to m_valid is SYNC_STAGES + CLK_DIV/2 + 9*CLK_DIV + 1 clocks, i.e. 193 with defaults.
- FIFO:
  - Synchronous, first-word fall-through; m_data is valid in the same cycle m_valid is high.
  - Pop occurs when m_valid && m_ready.
  - Push while full (fill==FIFO_DEPTH) drops the new byte and sets overflow. Existing contents are unchanged.
  - Push and pop in the same cycle: a full FIFO performs both and no overflow occurs; an empty FIFO accepts the push (no pop, since m_valid=0); fill is unchanged when both occur.
  - Pointers are $clog2(FIFO_DEPTH) bits, wrapping modulo depth; full/empty are derived from fill.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the set wins.
- A break (rx held low) produces one framing error. The FSM then waits in IDLE for rx_s==1 before arming for a new start bit; an idle_seen flag is needed for this.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP};
  - constant UART_BITS=8;
  - function for the default divider from clock frequency and baud rate.
- Sub-module sync_fifo, parameterised on width and depth, holding the storage, pointers and fill.
- The receiver FSM, synchronizer and flags stay in the top module.

Test Plan:
- Single byte 0x55 at CLK_DIV=20, m_ready=1 → m_valid pulses once with m_data=0x55 exactly 193 clks after the start edge; frame_err=0.
- Back-to-back bytes 0x00, 0xFF, 0xA5, 0x7E with no idle gap, m_ready=1 → all four are received in order; fill never exceeds 1.
- m_ready=0 while 17 bytes 0x01..0x11 are sent → fill=16 and overflow=1. Draining then yields 0x01..0x10, and 0x11 is absent.
- Byte 0x3C sent with its stop bit driven low → no push and frame_err=1. A following valid 0x42 is received. err_clr clears the flag.
- 4-clk low glitch on idle rx → no data, no error, FSM back in IDLE.
- reset asserted at mid-bit 4 of 0x99 → m_valid=0 and fill=0. The next full frame 0x12 is received correctly.
